// File: rtl/rgb_pwm_encoder.sv
// Three-channel PWM encoder: duty triples arrive by valid/ready and are applied
// only at period wrap, either directly or as a fixed-step fade.
module rgb_pwm_encoder #(
  parameter int W         = 8,
  parameter int FADE_STEP = 0,
  parameter bit POLARITY  = 1'b0
) (
  input  logic         clk_div,
  input  logic         rst,
  input  logic [W-1:0] r_duty_in,
  input  logic [W-1:0] g_duty_in,
  input  logic [W-1:0] b_duty_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         pwm_r,
  output logic         pwm_g,
  output logic         pwm_b,
  output logic         period_tick,
  output logic         fading
);

  localparam logic [W-1:0] MAX  = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] STEP = W'(FADE_STEP);

  typedef enum logic {IDLE, PEND} state_t;

  state_t               state, state_nx;
  logic [W-1:0]         cnt;
  logic [2:0][W-1:0]    tgt, act, act_nx;
  logic                 wrap, accept, apply;

  // Difference is compared before stepping, so W-bit arithmetic never wraps.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] a,
                                                input logic [W-1:0] t);
    if (STEP == '0)
      return t;
    if (a < t)
      return ((t - a) > STEP) ? a + STEP : t;
    if (a > t)
      return ((a - t) > STEP) ? a - STEP : t;
    return a;
  endfunction

  always_comb begin
    state_nx   = state;
    act_nx     = act;
    apply      = 1'b0;
    wrap       = (cnt == MAX);
    load_ready = (state == IDLE);
    fading     = (state == PEND);
    accept     = load_valid && (state == IDLE);
    case (state)
      IDLE: begin
        if (load_valid)
          state_nx = PEND;
      end
      PEND: begin
        if (wrap) begin
          apply = 1'b1;
          for (int unsigned i = 0; i < 3; i++)
            act_nx[i] = step_toward(act[i], tgt[i]);
          if (act_nx == tgt)
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      tgt         <= '0;
      act         <= '0;
      pwm_r       <= POLARITY;
      pwm_g       <= POLARITY;
      pwm_b       <= POLARITY;
    end else begin
      cnt         <= wrap ? '0 : cnt + W'(1);
      period_tick <= wrap;
      if (accept)
        tgt <= {b_duty_in, g_duty_in, r_duty_in};
      if (apply)
        act <= act_nx;
      pwm_r <= (cnt < act[0]) ^ POLARITY;
      pwm_g <= (cnt < act[1]) ^ POLARITY;
      pwm_b <= (cnt < act[2]) ^ POLARITY;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_encoder.sv
// Bench for rgb_pwm_encoder: a jump-mode and a fade-mode instance checked
// against a period-level reference model of duty application.
module tb_rgb_pwm_encoder;

  localparam int FSTEP = 16;
  localparam int STEPS [2] = '{0, FSTEP};
  localparam bit POLS  [2] = '{1'b0, 1'b1};

  logic       clk_div = 1'b0;
  logic       rst;
  logic [7:0] r_in [2];
  logic [7:0] g_in [2];
  logic [7:0] b_in [2];
  logic       vld  [2];
  logic       rdy  [2];
  logic       pr   [2];
  logic       pg   [2];
  logic       pb   [2];
  logic       tick [2];
  logic       fad  [2];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_div = ~clk_div;

  rgb_pwm_encoder #(.W(8), .FADE_STEP(0), .POLARITY(1'b0)) u_jump (
    .clk_div(clk_div), .rst(rst),
    .r_duty_in(r_in[0]), .g_duty_in(g_in[0]), .b_duty_in(b_in[0]),
    .load_valid(vld[0]), .load_ready(rdy[0]),
    .pwm_r(pr[0]), .pwm_g(pg[0]), .pwm_b(pb[0]),
    .period_tick(tick[0]), .fading(fad[0])
  );

  rgb_pwm_encoder #(.W(8), .FADE_STEP(FSTEP), .POLARITY(1'b1)) u_fade (
    .clk_div(clk_div), .rst(rst),
    .r_duty_in(r_in[1]), .g_duty_in(g_in[1]), .b_duty_in(b_in[1]),
    .load_valid(vld[1]), .load_ready(rdy[1]),
    .pwm_r(pr[1]), .pwm_g(pg[1]), .pwm_b(pb[1]),
    .period_tick(tick[1]), .fading(fad[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in period, pending flag and duty values per instance.
  int m_cnt;
  bit m_tick;
  bit m_wrap, m_take, m_done;
  bit m_pend [2];
  bit m_acc  [2];
  int m_act  [2][3];
  int m_tgt  [2][3];
  int m_per  [2][3];
  int m_in   [3];

  function automatic int approach(input int a, input int t, input int s);
    int d;
    if (s == 0) return t;
    d = t - a;
    if (d > s)  d = s;
    if (d < -s) d = -s;
    return a + d;
  endfunction

  initial begin
    forever begin
      @(posedge clk_div or posedge rst);
      if (rst) begin
        m_cnt  = 0;
        m_tick = 0;
        for (int d = 0; d < 2; d++) begin
          m_pend[d] = 0;
          m_acc[d]  = 0;
          for (int c = 0; c < 3; c++) begin
            m_act[d][c] = 0; m_tgt[d][c] = 0; m_per[d][c] = 0;
          end
        end
      end else begin
        m_wrap = (m_cnt == 254);
        for (int d = 0; d < 2; d++) begin
          m_take = vld[d] && !m_pend[d];
          m_in[0] = int'(r_in[d]); m_in[1] = int'(g_in[d]); m_in[2] = int'(b_in[d]);
          if (m_wrap)
            for (int c = 0; c < 3; c++) m_per[d][c] = m_act[d][c];
          if (m_wrap && m_pend[d]) begin
            m_done = 1;
            for (int c = 0; c < 3; c++) begin
              m_act[d][c] = approach(m_act[d][c], m_tgt[d][c], STEPS[d]);
              if (m_act[d][c] != m_tgt[d][c]) m_done = 0;
            end
            if (m_done) m_pend[d] = 0;
          end
          if (m_take) begin
            for (int c = 0; c < 3; c++) m_tgt[d][c] = m_in[c];
            m_pend[d] = 1;
          end
          m_acc[d] = m_take;
        end
        m_tick = m_wrap;
        m_cnt  = m_wrap ? 0 : m_cnt + 1;
      end
    end
  end

  // Monitor: handshake/tick every cycle, active time and contiguity per period.
  int hi  [2][3];
  int run [2][3];
  bit lo  [2][3];
  bit smp [3];

  initial begin
    forever begin
      @(negedge clk_div);
      for (int d = 0; d < 2; d++) begin
        check_eq($sformatf("ready%0d", d), 32'(rdy[d]), 32'(!m_pend[d]));
        check_eq($sformatf("fading%0d", d), 32'(fad[d]), 32'(m_pend[d]));
        check_eq($sformatf("tick%0d", d), 32'(tick[d]), 32'(m_tick));
        if (rst) begin
          for (int c = 0; c < 3; c++) begin hi[d][c] = 0; run[d][c] = 0; lo[d][c] = 0; end
        end else begin
          smp[0] = pr[d] ^ POLS[d];
          smp[1] = pg[d] ^ POLS[d];
          smp[2] = pb[d] ^ POLS[d];
          for (int c = 0; c < 3; c++) begin
            if (smp[c]) begin
              hi[d][c]++;
              if (!lo[d][c]) run[d][c]++;
            end else begin
              lo[d][c] = 1;
            end
          end
          if (m_tick) begin
            for (int c = 0; c < 3; c++) begin
              check_eq($sformatf("hi_d%0d_c%0d", d, c), hi[d][c], m_per[d][c]);
              check_eq($sformatf("run_d%0d_c%0d", d, c), run[d][c], m_per[d][c]);
              hi[d][c] = 0; run[d][c] = 0; lo[d][c] = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 260 + 10) begin
      @(posedge clk_div); #1;
      cyc++;
      if (m_tick) seen++;
    end
    if (seen < n) check_eq("tick_timeout", seen, n);
  endtask

  task automatic send(input int d, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int cyc = 0;
    r_in[d] = r; g_in[d] = g; b_in[d] = b; vld[d] = 1'b1;
    do begin
      @(posedge clk_div); #1;
      cyc++;
    end while (!m_acc[d] && cyc < 20 * 255);
    if (!m_acc[d]) check_eq("send_timeout", 0, 1);
    vld[d] = 1'b0;
  endtask

  task automatic align_to_max();
    int cyc = 0;
    while (m_cnt != 254 && cyc < 300) begin
      @(posedge clk_div); #1;
      cyc++;
    end
    if (m_cnt != 254) check_eq("align_timeout", m_cnt, 254);
  endtask

  task automatic count_fade(input int d, output int n);
    int cyc = 0;
    bit busy = 1;
    n = 0;
    while (busy && cyc < 20 * 255) begin
      @(negedge clk_div);
      cyc++;
      if (tick[d]) n++;
      if (!fad[d]) busy = 0;
    end
    if (busy) check_eq("fade_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int d);
    int cyc = 0;
    while (m_pend[d] && cyc < 20 * 255) begin
      @(posedge clk_div); #1;
      cyc++;
    end
    if (m_pend[d]) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_pwm_r"}, 32'(pr[d]), 32'(POLS[d]));
      check_eq({tag, "_pwm_g"}, 32'(pg[d]), 32'(POLS[d]));
      check_eq({tag, "_pwm_b"}, 32'(pb[d]), 32'(POLS[d]));
      check_eq({tag, "_ready"}, 32'(rdy[d]), 1);
      check_eq({tag, "_fading"}, 32'(fad[d]), 0);
      check_eq({tag, "_tick"}, 32'(tick[d]), 0);
    end
  endtask

  int nw;
  int dsel;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; r_in[d] = '0; g_in[d] = '0; b_in[d] = '0;
    end
    repeat (3) @(posedge clk_div);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;

    // Idle periods: ticks every 255 cycles, outputs stay inactive.
    wait_ticks(3);

    // Direct load with full-scale, zero and mid-scale duties.
    send(0, 8'd255, 8'd0, 8'd128);
    check_eq("jump_ready_low", 32'(rdy[0]), 0);
    wait_ticks(3);

    // Back-pressure: second request held through PEND.
    send(0, 8'd50, 8'd60, 8'd70);
    send(0, 8'd10, 8'd20, 8'd30);
    wait_ticks(3);

    // Fade up and down across full scale.
    wait_ticks(1);
    send(1, 8'd255, 8'd255, 8'd255);
    count_fade(1, nw);
    check_eq("fade_up_wraps", nw, 16);
    wait_ticks(2);
    send(1, 8'd0, 8'd0, 8'd0);
    count_fade(1, nw);
    check_eq("fade_down_wraps", nw, 16);
    wait_ticks(2);

    // Load accepted on the wrap edge itself.
    align_to_max();
    send(0, 8'd200, 8'd100, 8'd50);
    check_eq("bnd_tick", 32'(tick[0]), 1);
    check_eq("bnd_ready", 32'(rdy[0]), 0);
    wait_ticks(3);

    // Same, then asynchronous reset while pending discards the target.
    align_to_max();
    send(0, 8'd90, 8'd90, 8'd90);
    send(1, 8'd90, 8'd90, 8'd90);
    repeat (100) @(posedge clk_div);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk_div); #1;
    rst = 1'b0;
    wait_ticks(3);

    // Randomized loads on both instances.
    for (int i = 0; i < 6; i++) begin
      dsel = int'($urandom_range(1, 0));
      send(dsel, 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(300, 0)) @(posedge clk_div);
      #1;
    end
    wait_idle(0);
    wait_idle(1);
    wait_ticks(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_encoder.md
# rgb_pwm_encoder

Three-channel PWM generator that turns 8-bit per-channel duty values from the colour sequencer into R/G/B LED drive waveforms. Duty updates are accepted through a valid/ready handshake and applied only at a PWM period boundary, either immediately or by a stepwise fade. It sits between the colour-state logic and the LED pins and runs on the PWM tick clock.

## Interface
- W, 8: duty/counter width.
- FADE_STEP, 0: per-period change in duty; 0 means jump directly to the target.
- POLARITY, 0: 0 means outputs are active-high; 1 means all pwm_* outputs are inverted.

Ports:
- clk_div  in  1  PWM tick clock.
- rst  in  1  asynchronous, active-high reset.
- r_duty_in  in  W  requested red duty.
- g_duty_in  in  W  requested green duty.
- b_duty_in  in  W  requested blue duty.
- load_valid  in  1  duty triple on inputs is valid.
- load_ready  out  1  block can accept a triple.
- pwm_r, pwm_g, pwm_b  out  1 each  registered PWM outputs.
- period_tick  out  1  one-cycle pulse at the start of each period.
- fading  out  1  an accepted target has not yet been fully applied.

## Operation
- Period counter cnt counts 0..MAX, where MAX = 2^W-2, then wraps to 0. The period is 2^W-1 cycles (255 for W=8).
- Each channel has three registers:
  - tgt_x: target, written on handshake.
  - act_x: active duty, used for comparison.
  - raw compare: (cnt < act_x). Duty 0 gives always low; duty 2^W-1 gives always high.
- pwm_x <= (cnt < act_x) XOR POLARITY, evaluated every clock.
- FSM has two states:
  - IDLE: load_ready=1, fading=0. On load_valid&&load_ready, capture all three inputs into tgt_*, go to PEND.
  - PEND: load_ready=0, fading=1. Inputs are ignored; load_valid may be held.
- Wrap update, performed at the edge where cnt==MAX, in PEND only. It uses tgt_* as held before that edge.
  - FADE_STEP=0: act_x <= tgt_x, then go to IDLE.
  - FADE_STEP>0, per channel:
    - if act<tgt: act <= (tgt-act > FADE_STEP) ? act+FADE_STEP : tgt.
    - if act>tgt: mirror of the above, moving down.
    - if equal: unchanged.
  - Go to IDLE when all three post-update values equal tgt_*; otherwise stay in PEND.
  - All arithmetic is W-bit unsigned, with a difference comparison before add/subtract, so no overflow or underflow is possible.
- In IDLE, act_* is unchanged at wrap.
- Handshake accepted in IDLE on the same edge where cnt==MAX:
  - tgt_* is captured and the state goes to PEND.
  - The act_* update happens at the following wrap, one full period later.

## Timing
- Reset values:
  - cnt=0, act_*=0, tgt_*=0, state IDLE.
  - pwm_r/g/b = POLARITY.
  - period_tick=0, load_ready=1, fading=0.
- pwm_* lags the cnt/act_* comparison by 1 cycle.
- New act_* affects pwm_* from the first cycle after the wrap edge, i.e. period-aligned with no partial periods.
- period_tick is registered: it is high for exactly the cycle in which cnt==0 following a wrap. It is not asserted for the first cnt==0 after reset.
- Handshake latency:
  - Accepted one edge after load_valid rises, if ready.
  - load_ready drops on that edge and returns on the wrap edge that clears PEND.
  - A request held during PEND is accepted on the first edge after load_ready returns.
- Worst-case STEP=0 apply latency is 2^W-1 cycles from acceptance.
- With fade, the block needs ceil(|tgt-act|/FADE_STEP) wraps, using the largest difference across channels.
- Asynchronous rst mid-period or mid-fade immediately forces all reset values. Pending targets are discarded.

## Test plan
- Reset: assert rst mid-run. All pwm_*=0 (POLARITY=0), load_ready=1, fading=0, period_tick=0, and cnt restarts at 0 after release.
- Period/tick: no loads. period_tick pulses every 255 cycles and pwm_* stays low.
- STEP=0 load R=255, G=0, B=128:
  - load_ready goes low until the next wrap.
  - In the following period, pwm_r is high for 255 cycles, pwm_g for 0 cycles, and pwm_b for exactly 128 cycles starting right after period_tick.
- Back-pressure: hold load_valid with R=10 during PEND.
  - No capture occurs during PEND.
  - Accepted on the edge after load_ready returns.
  - Applied at the subsequent wrap, so the pwm_r high time is 10.
- FADE_STEP=16, 0→255 on all channels:
  - act takes 16,32,…,240, then 255 on the 16th wrap.
  - fading clears on that wrap.
  - Then fade 255→0 in 16 wraps.
- Boundary: load accepted on the cnt==MAX edge.
  - act_* stays unchanged through the next period.
  - act_* updates one full period later.
  - Repeat with rst asserted during PEND: the target is discarded and act=0.
